// File: rtl/sram_mem_controller_pkg.sv
// Shared types and default constants for the MEM-stage SRAM controller.
// Imported by the interface, the controller and the bench.
package sram_mem_controller_pkg;

  localparam int          SRAM_ADDR_W      = 18;
  localparam int          SRAM_WAIT_CYCLES = 4;
  localparam logic [31:0] DATA_MEM_BASE    = 32'd1024;

  // Halfword select appended to the word index on SRAM_ADDR.
  localparam logic PHASE_LOW  = 1'b0;
  localparam logic PHASE_HIGH = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sram_mem_controller_if.sv
// Pipeline-side request/response bundle between the MEM stage and the SRAM controller.
// The pipeline is the master; the controller is the slave.
interface sram_mem_controller_if;

  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output rd_en,
    output wr_en,
    output address,
    output write_data,
    input  read_data,
    input  ready
  );

  modport slave (
    input  rd_en,
    input  wr_en,
    input  address,
    input  write_data,
    output read_data,
    output ready
  );

endinterface

// File: rtl/sram_mem_controller.sv
// Splits each 32-bit MEM-stage access into two timed 16-bit transfers on an
// asynchronous SRAM; ready stalls the pipeline until the second half finishes.
module sram_mem_controller
  import sram_mem_controller_pkg::*;
#(
  parameter int          ADDR_W      = SRAM_ADDR_W,
  parameter int          WAIT_CYCLES = SRAM_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = DATA_MEM_BASE
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_mem_controller_if.slave   bus,
  inout  wire  [15:0]            SRAM_DQ,
  output logic [ADDR_W-1:0]      SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  localparam int                WORD_W   = ADDR_W - 1;
  localparam int                CNT_W    = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                wr_op_q, wr_op_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [15:0]         low_q, low_d;

  logic [WORD_W-1:0]   word_in;
  logic                req;
  logic                active;
  logic                phase;
  logic                last_cyc;
  logic                dq_drive;
  logic [15:0]         dq_out;

  // Rebase to the data-memory window, drop the byte offset, wrap to SRAM size.
  assign word_in  = WORD_W'((bus.address - BASE_ADDR) >> 2);
  assign req      = bus.rd_en | bus.wr_en;
  assign active   = (state_q == ST_LOW) || (state_q == ST_HIGH);
  assign phase    = (state_q == ST_HIGH) ? PHASE_HIGH : PHASE_LOW;
  assign last_cyc = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    wr_op_d = wr_op_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    low_d   = low_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_LOW;
          cnt_d   = '0;
          wr_op_d = bus.wr_en;
          word_d  = word_in;
          wdata_d = bus.write_data;
        end
      end
      ST_LOW: begin
        if (last_cyc) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          if (!wr_op_q) low_d = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (last_cyc) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          if (!wr_op_q) rdata_d = {SRAM_DQ, low_q};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Request payload is only meaningful while an access is in flight.
  always_ff @(posedge clk) begin
    wr_op_q <= wr_op_d;
    word_q  <= word_d;
    wdata_q <= wdata_d;
    low_q   <= low_d;
  end

  // Strobes decode straight from registered state so an async reset parks them at once.
  always_comb begin
    SRAM_CE_N = ~active;
    SRAM_UB_N = ~active;
    SRAM_LB_N = ~active;
    SRAM_OE_N = ~(active & ~wr_op_q);
    SRAM_WE_N = ~(active & wr_op_q & ~last_cyc);
    SRAM_ADDR = active ? {word_q, phase} : '0;
  end

  // Write data stays on the bus through the last cycle to give WE_N rising edge hold time.
  assign dq_drive = active & wr_op_q;
  assign dq_out   = (phase == PHASE_HIGH) ? wdata_q[31:16] : wdata_q[15:0];
  assign SRAM_DQ  = dq_drive ? dq_out : 16'hzzzz;

  assign bus.ready     = ((state_q == ST_IDLE) & ~req) | (state_q == ST_DONE);
  assign bus.read_data = rdata_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: behavioural SRAM plus a word-level scoreboard.
module tb_sram_mem_controller;

  localparam int          ADDR_W = 18;
  localparam int          W      = 4;
  localparam int          LAT    = 2 * W + 1;
  localparam logic [31:0] BASE   = 32'd1024;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  wire  [15:0]        SRAM_DQ;
  logic [ADDR_W-1:0]  SRAM_ADDR;
  logic               SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

  sram_mem_controller_if bus();

  sram_mem_controller #(
    .ADDR_W     (ADDR_W),
    .WAIT_CYCLES(W),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .SRAM_DQ  (SRAM_DQ),
    .SRAM_ADDR(SRAM_ADDR),
    .SRAM_WE_N(SRAM_WE_N),
    .SRAM_OE_N(SRAM_OE_N),
    .SRAM_CE_N(SRAM_CE_N),
    .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N)
  );

  always #5 clk = ~clk;

  // sram_model_16: asynchronous 16-bit SRAM, reads while OE_N low, stores while WE_N low.
  logic [15:0] sram_mem [0:(1<<ADDR_W)-1];
  assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? sram_mem[SRAM_ADDR] : 16'hzzzz;
  always @(negedge clk) begin
    if (!SRAM_CE_N && !SRAM_WE_N) sram_mem[SRAM_ADDR] <= SRAM_DQ;
  end

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd  = 32'h0;

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] d;
    d = (a - BASE) >> 2;
    return int'(d & 32'h0001_FFFF);
  endfunction

  function automatic logic [4:0] strobes();
    return {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_OE_N};
  endfunction

  // One full access from the IDLE cycle through DONE, checked cycle by cycle.
  task automatic run_access(input bit do_wr, input bit do_rd, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit scramble,
                            input bit hold_rd, input logic [31:0] next_addr);
    int          wd;
    bit          ph;
    int          k;
    logic [17:0] exp_addr;
    logic [15:0] exp_dq;
    logic [4:0]  exp_strb;
    logic [31:0] exp_rd;
    @(negedge clk);
    checks++;
    if (bus.ready !== !(bus.rd_en | bus.wr_en))
      $display("FAIL idle_ready: got %b expected %b", bus.ready, !(bus.rd_en | bus.wr_en));
    bus.wr_en = do_wr; bus.rd_en = do_rd; bus.address = addr; bus.write_data = wdata;
    wd = word_of(addr);
    exp_rd = ref_mem.exists(wd) ? ref_mem[wd] : 32'h0;
    #1;
    checks++;
    if (bus.ready !== 1'b0) begin
      failures++; $display("FAIL req_ready: got %b expected 0", bus.ready);
    end
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      if (scramble && c == 3) begin
        bus.address = 32'd2048; bus.write_data = 32'h0; bus.wr_en = 1'b0; bus.rd_en = 1'b1;
      end
      if (c <= 2 * W) begin
        ph       = (c > W);
        k        = ph ? c - W - 1 : c - 1;
        exp_addr = 18'(wd * 2 + int'(ph));
        exp_strb = do_wr ? {3'b000, (k == W - 1), 1'b1} : 5'b00010;
        exp_dq   = ph ? wdata[31:16] : wdata[15:0];
        checks++;
        if (strobes() !== exp_strb) begin
          failures++; $display("FAIL strobes c=%0d: got %b expected %b", c, strobes(), exp_strb);
        end
        checks++;
        if (SRAM_ADDR !== exp_addr) begin
          failures++; $display("FAIL sram_addr c=%0d: got %0d expected %0d", c, SRAM_ADDR, exp_addr);
        end
        checks++;
        if (bus.ready !== 1'b0) begin
          failures++; $display("FAIL busy_ready c=%0d: got %b expected 0", c, bus.ready);
        end
        if (do_wr) begin
          checks++;
          if (SRAM_DQ !== exp_dq) begin
            failures++; $display("FAIL write_dq c=%0d: got %h expected %h", c, SRAM_DQ, exp_dq);
          end
        end
      end else begin
        checks++;
        if (bus.ready !== 1'b1) begin
          failures++; $display("FAIL done_ready: got %b expected 1", bus.ready);
        end
        checks++;
        if (strobes() !== 5'b11111) begin
          failures++; $display("FAIL done_strobes: got %b expected 11111", strobes());
        end
        if (!do_wr) last_rd = exp_rd;
        checks++;
        if (bus.read_data !== last_rd) begin
          failures++; $display("FAIL read_data addr=%h: got %h expected %h", addr, bus.read_data, last_rd);
        end
        bus.wr_en = 1'b0; bus.rd_en = hold_rd; bus.address = next_addr;
      end
    end
    if (do_wr) ref_mem[wd] = wdata;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.rd_en = 1'b1; bus.wr_en = 1'b0; bus.address = 32'd1032; bus.write_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (strobes() !== 5'b11111) begin
        failures++; $display("FAIL reset_strobes: got %b expected 11111", strobes());
      end
      checks++;
      if (bus.read_data !== 32'h0 || SRAM_ADDR !== 18'h0) begin
        failures++; $display("FAIL reset_regs: got rd=%h addr=%h expected 0/0", bus.read_data, SRAM_ADDR);
      end
    end
    bus.rd_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || strobes() !== 5'b11111) begin
      failures++; $display("FAIL post_reset_idle: got ready=%b strb=%b expected 1/11111", bus.ready, strobes());
    end
  endtask

  task automatic test_write();
    run_access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    checks++;
    if (sram_mem[4] !== 16'hBEEF || sram_mem[5] !== 16'hDEAD) begin
      failures++; $display("FAIL write_mem: got %h_%h expected dead_beef", sram_mem[5], sram_mem[4]);
    end
  endtask

  task automatic test_read();
    run_access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_latching();
    sram_mem[4] = 16'h0; sram_mem[5] = 16'h0;
    run_access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
    checks++;
    if (sram_mem[4] !== 16'hBEEF || sram_mem[5] !== 16'hDEAD) begin
      failures++; $display("FAIL latch_mem: got %h_%h expected dead_beef", sram_mem[5], sram_mem[4]);
    end
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b1, 32'd1036, 32'h12345678, 1'b0, 1'b1, 32'd1036);
    checks++;
    if (sram_mem[6] !== 16'h5678 || sram_mem[7] !== 16'h1234) begin
      failures++; $display("FAIL prio_mem: got %h_%h expected 1234_5678", sram_mem[7], sram_mem[6]);
    end
    run_access(1'b0, 1'b1, 32'd1036, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    bus.wr_en = 1'b1; bus.rd_en = 1'b0; bus.address = 32'd1032; bus.write_data = 32'hDEADBEEF;
    for (int c = 1; c <= 3; c++) @(negedge clk);
    rst = 1'b0;
    #1;
    last_rd = 32'h0;
    checks++;
    if (strobes() !== 5'b11111 || SRAM_ADDR !== 18'h0) begin
      failures++; $display("FAIL abort_strobes: got %b addr=%h expected 11111/0", strobes(), SRAM_ADDR);
    end
    checks++;
    if (bus.read_data !== 32'h0) begin
      failures++; $display("FAIL abort_rdata: got %h expected 0", bus.read_data);
    end
    bus.wr_en = 1'b0;
    #1;
    checks++;
    if (bus.ready !== 1'b1) begin
      failures++; $display("FAIL abort_idle_ready: got %b expected 1", bus.ready);
    end
    @(negedge clk);
    rst = 1'b1;
    run_access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] d;
    int          w;
    bit          wr;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      a = BASE + 32'(i * 4) + 32'($urandom_range(0, 3));
      run_access(1'b1, 1'b0, a, d, 1'b0, 1'b0, 32'h0);
    end
    for (int i = 0; i < 24; i++) begin
      w  = $urandom_range(0, 15);
      wr = ($urandom_range(0, 2) == 0);
      d  = $urandom;
      // Occasionally alias through the top of SRAM to exercise the wrap.
      a  = BASE + 32'(w * 4) + 32'($urandom_range(0, 3)) + (($urandom_range(0, 3) == 0) ? 32'h0008_0000 : 32'h0);
      run_access(wr, ~wr, a, d, 1'b0, 1'b0, 32'h0);
    end
  endtask

  initial begin
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.address = 32'h0; bus.write_data = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_latching();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
